// File: rtl/alu_result_collector_if.sv
// rtl/alu_result_collector_if.sv - result beat input and assembled word output bundle
//
// Purpose: groups the ALU result beat stream and the assembled-word handshake.
//   master : collector side (consumes beats, drives the assembled word)
//   slave  : environment side (drives beats, consumes the assembled word)
// Signals:
//   result_valid, result, result_last, result_rst : beat stream from ALU (no ready)
//   out_valid, out_ready, out_data, out_beats, out_trunc : assembled word handshake
//   out_parity : even parity of out_data (only with RESULT_PARITY_EN)
interface alu_result_collector_if #(
  parameter int RESULT_BUS_WIDTH      = 8,
  parameter int RESULT_MAX_DATA_WIDTH = 32
);
  localparam int MAX_BEATS = RESULT_MAX_DATA_WIDTH / RESULT_BUS_WIDTH;
  localparam int BCW       = $clog2(MAX_BEATS + 1);

  logic                             result_valid;
  logic [RESULT_BUS_WIDTH-1:0]      result;
  logic                             result_last;
  logic                             result_rst;
  logic                             out_valid;
  logic                             out_ready;
  logic [RESULT_MAX_DATA_WIDTH-1:0] out_data;
  logic [BCW-1:0]                   out_beats;
  logic                             out_trunc;
`ifdef RESULT_PARITY_EN
  logic                             out_parity;
`endif

  modport master (
    input  result_valid, result, result_last, result_rst, out_ready,
`ifdef RESULT_PARITY_EN
    output out_parity,
`endif
    output out_valid, out_data, out_beats, out_trunc
  );

  modport slave (
    output result_valid, result, result_last, result_rst, out_ready,
`ifdef RESULT_PARITY_EN
    input  out_parity,
`endif
    input  out_valid, out_data, out_beats, out_trunc
  );
endinterface

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - assembles ALU result beats into words and buffers them in a FIFO
//
// Purpose: captures LSB-first result beats, builds one RESULT_MAX_DATA_WIDTH word per
//   result_last, and queues completed words for a valid/ready consumer. Words that
//   arrive while the FIFO is full (and not popping) are dropped and flagged.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   bus     : alu_result_collector_if.master (beat input, word output handshake)
//   ovf_err : sticky, a completed word was dropped because the FIFO was full
// Configuration macro: RESULT_PARITY_EN adds bus.out_parity, stored per FIFO entry.
module alu_result_collector #(
  parameter int RESULT_BUS_WIDTH      = 8,
  parameter int RESULT_MAX_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH            = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_collector_if.master bus,
  output logic                   ovf_err
);
  localparam int MAX_BEATS = RESULT_MAX_DATA_WIDTH / RESULT_BUS_WIDTH;
  localparam int BCW       = $clog2(MAX_BEATS + 1);
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [BCW-1:0] MAX_B  = BCW'(MAX_BEATS);
  localparam logic [PW-1:0]  LAST_P = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]  FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t state, next_state;

  logic [RESULT_MAX_DATA_WIDTH-1:0] assy, merged;
  logic [BCW-1:0]                   cnt, nxt_cnt;
  logic                             trunc, nxt_trunc;
  logic                             beat, abort, push_req, push_ok, pop, full;

  logic [RESULT_MAX_DATA_WIDTH-1:0] data_mem  [FIFO_DEPTH];
  logic [BCW-1:0]                   beats_mem [FIFO_DEPTH];
  logic                             trunc_mem [FIFO_DEPTH];
`ifdef RESULT_PARITY_EN
  logic                             par_mem   [FIFO_DEPTH];
`endif
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Abort outranks any beat presented in the same cycle.
  assign abort = bus.result_rst;
  assign beat  = bus.result_valid & ~abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (beat && bus.result_last) push_req   = 1'b1;
        else if (beat)               next_state = COLLECT;
      end
      COLLECT: begin
        if (abort) begin
          next_state = IDLE;
        end else if (beat && bus.result_last) begin
          push_req   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Word as it stands including the current beat; beats past MAX_BEATS leave data untouched.
  always_comb begin
    merged = assy;
    for (int k = 0; k < MAX_BEATS; k++) begin
      if (cnt == BCW'(k)) merged[k*RESULT_BUS_WIDTH +: RESULT_BUS_WIDTH] = bus.result;
    end
    nxt_cnt   = (cnt == MAX_B) ? cnt : cnt + 1'b1;
    nxt_trunc = trunc | (cnt == MAX_B);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      assy  <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else if (abort || push_req) begin
      assy  <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else if (beat) begin
      assy  <= merged;
      cnt   <= nxt_cnt;
      trunc <= nxt_trunc;
    end
  end

  assign full    = (count == FULL_C);
  assign pop     = bus.out_valid & bus.out_ready;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign push_ok = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr]  <= merged;
      beats_mem[wr_ptr] <= nxt_cnt;
      trunc_mem[wr_ptr] <= nxt_trunc;
`ifdef RESULT_PARITY_EN
      par_mem[wr_ptr]   <= ^merged;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) ovf_err <= 1'b1;
    end
  end

  // Head fields are gated by out_valid so the outputs read 0 whenever the FIFO is empty,
  // which also covers reset without having to clear the storage array.
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? data_mem[rd_ptr]  : '0;
  assign bus.out_beats = bus.out_valid ? beats_mem[rd_ptr] : '0;
  assign bus.out_trunc = bus.out_valid ? trunc_mem[rd_ptr] : 1'b0;
`ifdef RESULT_PARITY_EN
  assign bus.out_parity = bus.out_valid ? par_mem[rd_ptr] : 1'b0;
`endif
endmodule
